// File: rtl/weight_fetch_pkg.sv
// Shared types and default sizes for the weight fetch sequencer and its output buffer.
package weight_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

    localparam int WF_ADDR_W    = 8;
    localparam int WF_DATA_W    = 8;
    localparam int WF_BUF_DEPTH = 2;

endpackage

// File: rtl/weight_skid_fifo.sv
// Small synchronous FIFO buffering {last, data} between the weight memory and the MAC.
// Flush empties it in one cycle and takes priority over a simultaneous push.
module weight_skid_fifo
    import weight_fetch_pkg::*;
#(
    parameter int WIDTH = WF_DATA_W + 1,
    parameter int DEPTH = WF_BUF_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [OCC_W-1:0] occupancy,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (occupancy == OCC_W'(DEPTH));
    assign empty    = (occupancy == '0);
    assign pop_ok   = pop && !empty;
    // A full buffer still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   occupancy <= occupancy + OCC_W'(1);
                2'b01:   occupancy <= occupancy - OCC_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Streams a run of sequential weights from the synchronous weight memory to the MAC.
// Define WFETCH_ABORT_EN to add an abort input that cancels a run in progress.
module weight_fetch_sequencer
    import weight_fetch_pkg::*;
#(
    parameter int ADDR_W    = WF_ADDR_W,
    parameter int DATA_W    = WF_DATA_W,
    parameter int BUF_DEPTH = WF_BUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
`ifdef WFETCH_ABORT_EN
    input  logic              abort,
`endif
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] w_data,
    output logic              w_valid,
    input  logic              w_ready,
    output logic              w_last
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    fetch_state_t      state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   count_q;
    logic [ADDR_W:0]   issued;
    logic              inflight;
    logic              inflight_last;

    logic [ADDR_W-1:0] next_addr;
    logic              last_issue;
    logic              has_credit;
    logic              issue;
    logic              pop;
    logic              abort_hit;
    logic              fifo_full;
    logic              fifo_empty;
    logic [OCC_W-1:0]  occupancy;
    logic [DATA_W:0]   fifo_head;

`ifdef WFETCH_ABORT_EN
    assign abort_hit = abort && (state != IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign pop        = !fifo_empty && w_ready;
    assign next_addr  = base_q + issued[ADDR_W-1:0];
    assign last_issue = ((issued + (ADDR_W+1)'(1)) == count_q);

    // A read may only be issued if its data is guaranteed a buffer slot when it lands.
    assign has_credit = (32'(occupancy) + 32'(inflight)) < (32'(BUF_DEPTH) + 32'(pop));
    assign issue      = (state == FETCH) && has_credit && !(fifo_full && !pop) && !abort_hit;
    assign mem_addr   = issue ? next_addr : addr_q;

    assign w_valid = !fifo_empty;
    assign w_data  = fifo_head[DATA_W-1:0];
    assign w_last  = fifo_head[DATA_W] && !fifo_empty;

    weight_skid_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (abort_hit),
        .push      (inflight),
        .push_data ({inflight_last, mem_data}),
        .pop       (pop),
        .pop_data  (fifo_head),
        .occupancy (occupancy),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            base_q        <= '0;
            addr_q        <= '0;
            count_q       <= '0;
            issued        <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            done          <= 1'b0;
            inflight      <= issue;
            inflight_last <= issue && last_issue;
            if (issue) begin
                addr_q <= next_addr;
                issued <= issued + (ADDR_W+1)'(1);
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (count != '0) begin
                            state   <= FETCH;
                            busy    <= 1'b1;
                            base_q  <= base_addr;
                            count_q <= {1'b0, count};
                            issued  <= '0;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (abort_hit) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (issue && last_issue) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort_hit || (pop && fifo_head[DATA_W])) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Scoreboard bench for weight_fetch_sequencer; memory word at address a is a ^ 8'h5A.
// The abort scenario is compiled in only when WFETCH_ABORT_EN is defined.
module tb_weight_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] base_addr;
    logic [7:0] count;
    logic       busy;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_data = 8'h00;
    logic [7:0] w_data;
    logic       w_valid;
    logic       w_ready;
    logic       w_last;
`ifdef WFETCH_ABORT_EN
    logic       abort = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int start_cyc   = 0;
    int first_hs    = -1;
    int last_hs     = -1;
    int hs_count    = 0;
    int done_cyc;

    logic [8:0] exp_q[$];
    logic       stall_pending = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    weight_fetch_sequencer dut (
        .clk       (clk),
        .rst       (rst),
`ifdef WFETCH_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .w_data    (w_data),
        .w_valid   (w_valid),
        .w_ready   (w_ready),
        .w_last    (w_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        mem_data <= mem_addr ^ 8'h5A;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: got timeout, expected event", name);
    endtask

    task automatic pushExp(input logic [7:0] data, input logic last);
        exp_q.push_back({last, data});
    endtask

    task automatic applyStimulus(input logic [7:0] base, input logic [7:0] cnt);
        @(posedge clk);
        #1;
        base_addr = base;
        count     = cnt;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        start_cyc = cyc;
        first_hs  = -1;
        last_hs   = -1;
        hs_count  = 0;
    endtask

    task automatic waitDone(output int dc);
        dc = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) failNow("done_timeout");
    endtask

    task automatic waitHandshakes(input int target);
        int n;
        n = 0;
        while (hs_count < target && n < 50) begin
            @(posedge clk);
            n++;
        end
        if (hs_count < target) failNow("handshake_timeout");
    endtask

    // Scoreboard monitor: pops on every handshake and checks stall stability.
    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            stall_pending = 1'b0;
        end else if (w_valid) begin
            if (stall_pending) begin
                checkOutput("stall_data", 32'(w_data), 32'(held_data));
                checkOutput("stall_last", 32'(w_last), 32'(held_last));
            end
            if (w_ready) begin
                hs_count++;
                if (first_hs < 0) first_hs = cyc;
                if (w_last) last_hs = cyc;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_weight: got data 0x%0h, expected no weight", w_data);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("w_data", 32'(w_data), 32'(e[7:0]));
                    checkOutput("w_last", 32'(w_last), 32'(e[8]));
                end
                stall_pending = 1'b0;
            end else begin
                stall_pending = 1'b1;
                held_data     = w_data;
                held_last     = w_last;
            end
        end else if (stall_pending) begin
            checkOutput("stall_valid", 32'(w_valid), 32'd1);
            stall_pending = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] pat;
        rst       = 1'b1;
        start     = 1'b0;
        base_addr = 8'h00;
        count     = 8'h00;
        w_ready   = 1'b0;
        pat       = 4'b1001;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_done", 32'(done), 0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 0);
        checkOutput("rst_w_valid", 32'(w_valid), 0);
        checkOutput("rst_w_last", 32'(w_last), 0);
        checkOutput("rst_w_data", 32'(w_data), 0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        w_ready = 1'b1;

        $display("[TB] run A: base 0x10 count 4, ready high");
        pushExp(8'h4A, 1'b0);
        pushExp(8'h4B, 1'b0);
        pushExp(8'h48, 1'b0);
        pushExp(8'h49, 1'b1);
        applyStimulus(8'h10, 8'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) checkOutput("A_busy", 32'(busy), 1);
            checkOutput("A_mem_addr", 32'(mem_addr), 32'(8'h10 + i));
        end
        waitDone(done_cyc);
        checkOutput("A_first_valid_cycle", 32'(first_hs), 32'(start_cyc + 2));
        checkOutput("A_last_cycle", 32'(last_hs), 32'(start_cyc + 5));
        checkOutput("A_done_cycle", 32'(done_cyc), 32'(start_cyc + 6));
        checkOutput("A_busy_at_done", 32'(busy), 0);
        checkOutput("A_scoreboard_empty", 32'(exp_q.size()), 0);

        $display("[TB] run B: base 0xFE count 3, address wrap");
        pushExp(8'hA4, 1'b0);
        pushExp(8'hA5, 1'b0);
        pushExp(8'h5A, 1'b1);
        applyStimulus(8'hFE, 8'd3);
        @(negedge clk);
        checkOutput("B_mem_addr0", 32'(mem_addr), 32'h0FE);
        @(negedge clk);
        checkOutput("B_mem_addr1", 32'(mem_addr), 32'h0FF);
        @(negedge clk);
        checkOutput("B_mem_addr2", 32'(mem_addr), 32'h000);
        waitDone(done_cyc);
        checkOutput("B_done_cycle", 32'(done_cyc), 32'(start_cyc + 5));
        checkOutput("B_scoreboard_empty", 32'(exp_q.size()), 0);

        $display("[TB] run C: base 0x20 count 5, ready toggling");
        pushExp(8'h7A, 1'b0);
        pushExp(8'h7B, 1'b0);
        pushExp(8'h78, 1'b0);
        pushExp(8'h79, 1'b0);
        pushExp(8'h7E, 1'b1);
        applyStimulus(8'h20, 8'd5);
        done_cyc = -1;
        for (int k = 0; k < 100; k++) begin
            w_ready = pat[k % 4];
            @(negedge clk);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (done_cyc < 0) failNow("C_done_timeout");
        checkOutput("C_weights_seen", 32'(hs_count), 5);
        checkOutput("C_scoreboard_empty", 32'(exp_q.size()), 0);
        checkOutput("C_busy_at_done", 32'(busy), 0);
        @(posedge clk);
        #1;
        w_ready = 1'b1;

        $display("[TB] run D: empty run");
        applyStimulus(8'h55, 8'd0);
        @(negedge clk);
        checkOutput("D_done", 32'(done), 1);
        checkOutput("D_busy", 32'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("D_done_after", 32'(done), 0);
            checkOutput("D_w_valid", 32'(w_valid), 0);
            checkOutput("D_busy_after", 32'(busy), 0);
        end

        $display("[TB] run E: reset after second of 8 weights");
        pushExp(8'h1A, 1'b0);
        pushExp(8'h1B, 1'b0);
        applyStimulus(8'h40, 8'd8);
        waitHandshakes(2);
        #1;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("E_rst_busy", 32'(busy), 0);
        checkOutput("E_rst_done", 32'(done), 0);
        checkOutput("E_rst_mem_addr", 32'(mem_addr), 0);
        checkOutput("E_rst_w_valid", 32'(w_valid), 0);
        checkOutput("E_rst_w_last", 32'(w_last), 0);
        checkOutput("E_rst_w_data", 32'(w_data), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("E_no_done", 32'(done), 0);
            checkOutput("E_no_valid", 32'(w_valid), 0);
        end
        checkOutput("E_scoreboard_empty", 32'(exp_q.size()), 0);
        pushExp(8'hDA, 1'b0);
        pushExp(8'hDB, 1'b1);
        applyStimulus(8'h80, 8'd2);
        waitDone(done_cyc);
        checkOutput("E_rerun_done_cycle", 32'(done_cyc), 32'(start_cyc + 4));
        checkOutput("E_rerun_scoreboard_empty", 32'(exp_q.size()), 0);

`ifdef WFETCH_ABORT_EN
        $display("[TB] run F: abort during third of 6 weights");
        pushExp(8'h6A, 1'b0);
        pushExp(8'h6B, 1'b0);
        pushExp(8'h68, 1'b0);
        applyStimulus(8'h30, 8'd6);
        waitHandshakes(2);
        #1;
        abort     = 1'b1;
        start     = 1'b1;
        base_addr = 8'h99;
        count     = 8'd3;
        @(posedge clk);
        #1;
        abort = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("F_w_valid", 32'(w_valid), 0);
        checkOutput("F_done", 32'(done), 1);
        checkOutput("F_busy", 32'(busy), 0);
        @(negedge clk);
        checkOutput("F_busy_after", 32'(busy), 0);
        checkOutput("F_done_after", 32'(done), 0);
        checkOutput("F_scoreboard_empty", 32'(exp_q.size()), 0);
`endif

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
